opb_register_ppc2simulink: RTL and testbench

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

---
 rtl/opb_register_ppc2simulink_pkg.sv | 14 +
 rtl/opb_register_ppc2simulink_be.sv | 16 +
 rtl/opb_register_ppc2simulink.sv | 95 +++++++++
 tb/tb_opb_register_ppc2simulink.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/opb_register_ppc2simulink_pkg.sv
// Shared types and constants for the PPC-to-Simulink OPB register slave.
package opb_register_ppc2simulink_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   // Word offsets within the 8-byte aliased window.
   localparam logic [2:0] OFF_DATA = 3'h0;
   localparam logic [2:0] OFF_CNT  = 3'h4;

endpackage

// File: rtl/opb_register_ppc2simulink_be.sv
// Byte-lane write merge: lane k (big-endian, lane 0 = bits 31:24) takes new data when be[k] is set.
module opb_be_merge (
   input  logic [31:0] cur,
   input  logic [31:0] wdata,
   input  logic [0:3]  be,
   output logic [31:0] merged
);

   always_comb begin
      merged = cur;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) merged[31-8*k -: 8] = wdata[31-8*k -: 8];
      end
   end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave exposing one R/W data register to user logic plus a read-only write counter.
module opb_register_ppc2simulink
   import opb_register_ppc2simulink_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h010B0200,
   parameter logic [31:0] C_HIGHADDR   = 32'h010B02FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5",
   parameter logic [31:0] C_INIT       = 32'h0
) (
   input  logic        OPB_Clk,
   input  logic        OPB_Rst,
   input  logic [0:31] OPB_ABus,
   input  logic [0:3]  OPB_BE,
   input  logic [0:31] OPB_DBus,
   input  logic        OPB_RNW,
   input  logic        OPB_select,
   input  logic        OPB_seqAddr,
   output logic [0:31] Sl_DBus,
   output logic        Sl_xferAck,
   output logic        Sl_errAck,
   output logic        Sl_retry,
   output logic        Sl_toutSup,
   output logic [31:0] user_data_out,
   output logic        user_data_valid,
   output logic [31:0] user_wr_count
);

   state_t      state, state_next;
   logic [31:0] data_reg;
   logic [31:0] wr_count;
   logic [31:0] wdata;
   logic [31:0] merged;
   logic [2:0]  offset;
   logic        hit;
   logic        in_ack;
   logic        data_wr;
   logic        unused_ok;

   assign unused_ok = &{1'b0, OPB_seqAddr, C_OPB_AWIDTH[0], C_OPB_DWIDTH[0], C_FAMILY[0]};

   assign hit     = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign offset  = OPB_ABus[29:31] & 3'b100;
   assign in_ack  = (state == ST_ACK);
   assign data_wr = in_ack && !OPB_RNW && (offset == OFF_DATA);
   // DBus bit 0 is the MSB, so a plain assignment gives user bit 31-i = DBus bit i.
   assign wdata   = OPB_DBus;

   opb_be_merge u_merge (
      .cur    (data_reg),
      .wdata  (wdata),
      .be     (OPB_BE),
      .merged (merged)
   );

   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (hit) state_next = ST_ACK;
         ST_ACK:  state_next = ST_WAIT;
         ST_WAIT: if (!OPB_select) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Commit happens on the edge that ends the ACK cycle; valid follows in the next cycle.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
      if (!OPB_Rst) begin
         data_reg        <= C_INIT;
         wr_count        <= 32'h0;
         user_data_valid <= 1'b0;
      end else begin
         user_data_valid <= data_wr;
         if (data_wr) begin
            data_reg <= merged;
            wr_count <= wr_count + 32'h1;
         end
      end
   end

   assign Sl_xferAck    = in_ack;
   assign Sl_DBus       = (in_ack && OPB_RNW) ? ((offset == OFF_CNT) ? wr_count : data_reg) : 32'h0;
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = data_reg;
   assign user_wr_count = wr_count;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Directed bench for opb_register_ppc2simulink with a read-data scoreboard queue.
module tb_opb_register_ppc2simulink;
   import opb_register_ppc2simulink_pkg::*;

   localparam logic [31:0] BASE = 32'h010B0200;
   localparam logic [31:0] HIGH = 32'h010B02FF;
   localparam logic [31:0] INIT = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:31] abus = '0;
   logic [0:3]  be = '0;
   logic [0:31] dbus = '0;
   logic        rnw = 1'b0;
   logic        sel = 1'b0;
   logic        seq = 1'b0;
   logic [0:31] sl_dbus;
   logic        sl_ack, sl_err, sl_retry, sl_tout;
   logic [31:0] udata;
   logic        uvalid;
   logic [31:0] ucount;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd_q[$];
   logic [31:0] data_m;
   logic [31:0] cnt_m;
   int acks, valids;

   always #5 clk = ~clk;

   opb_register_ppc2simulink #(
      .C_BASEADDR (BASE),
      .C_HIGHADDR (HIGH),
      .C_INIT     (INIT)
   ) dut (
      .OPB_Clk         (clk),
      .OPB_Rst         (rst_n),
      .OPB_ABus        (abus),
      .OPB_BE          (be),
      .OPB_DBus        (dbus),
      .OPB_RNW         (rnw),
      .OPB_select      (sel),
      .OPB_seqAddr     (seq),
      .Sl_DBus         (sl_dbus),
      .Sl_xferAck      (sl_ack),
      .Sl_errAck       (sl_err),
      .Sl_retry        (sl_retry),
      .Sl_toutSup      (sl_tout),
      .user_data_out   (udata),
      .user_data_valid (uvalid),
      .user_wr_count   (ucount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic is_rd);
      logic [31:0] exp;
      if (sl_ack) begin
         acks++;
         if (is_rd) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else begin
               exp = rd_q.pop_front();
               check("rd_data", sl_dbus, exp);
            end
         end
      end else if (sl_dbus !== 32'h0) begin
         check("dbus_idle", sl_dbus, 32'h0);
      end
      if (uvalid) valids++;
   endtask

   // Holds select for 'hold' cycles, then idles 3 more, counting acks and valid pulses.
   task automatic xfer(input logic [31:0] addr, input logic is_rd, input logic [0:3] b,
                       input logic [31:0] wd, input int hold);
      acks = 0;
      valids = 0;
      @(negedge clk);
      abus = addr; rnw = is_rd; be = b; dbus = wd; sel = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         sample(is_rd);
      end
      @(negedge clk);
      sel = 1'b0; rnw = 1'b0; be = '0; dbus = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         sample(is_rd);
      end
   endtask

   initial begin
      data_m = INIT;
      cnt_m  = 32'h0;
      #2;
      check("rst_ack", {31'h0, sl_ack}, 32'h0);
      check("rst_dbus", sl_dbus, 32'h0);
      check("rst_data", udata, INIT);
      check("rst_cnt", ucount, 32'h0);
      check("rst_valid", {31'h0, uvalid}, 32'h0);
      check("tied_outs", {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Full-word write
      xfer(BASE, 1'b0, 4'b1111, 32'hDEADBEEF, 2);
      data_m = 32'hDEADBEEF; cnt_m++;
      check("w1_acks", acks, 1);
      check("w1_valids", valids, 1);
      check("w1_data", udata, data_m);
      check("w1_cnt", ucount, cnt_m);

      // Read back data register
      rd_q.push_back(data_m);
      xfer(BASE, 1'b1, 4'b1111, 32'h0, 2);
      check("r0_acks", acks, 1);
      check("r0_valids", valids, 0);

      // Partial byte-lane write
      xfer(BASE, 1'b0, 4'b0101, 32'h11223344, 2);
      data_m = 32'hDE22BE44; cnt_m++;
      check("w2_data", udata, data_m);
      check("w2_acks", acks, 1);
      check("w2_cnt", ucount, cnt_m);

      // Counter read with select held 5 cycles
      rd_q.push_back(cnt_m);
      xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 5);
      check("rc_acks", acks, 1);
      check("rc_q_empty", rd_q.size(), 0);

      // Write to the counter offset is acked and ignored
      xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h12345678, 2);
      check("wc_acks", acks, 1);
      check("wc_valids", valids, 0);
      check("wc_cnt", ucount, cnt_m);
      check("wc_data", udata, data_m);

      // BE=0000 still commits: valid pulses, count advances, data holds
      xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, 2);
      cnt_m++;
      check("be0_valids", valids, 1);
      check("be0_cnt", ucount, cnt_m);
      check("be0_data", udata, data_m);

      // Aliasing modulo 8 and top-of-window address
      rd_q.push_back(data_m);
      xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'h0, 2);
      check("alias_acks", acks, 1);
      rd_q.push_back(cnt_m);
      xfer(HIGH, 1'b1, 4'b1111, 32'h0, 2);
      check("high_acks", acks, 1);

      // Misses just outside the window on both sides
      xfer(HIGH + 32'h4, 1'b0, 4'b1111, 32'hA5A5A5A5, 10);
      check("miss_hi_acks", acks, 0);
      check("miss_hi_valids", valids, 0);
      check("miss_hi_data", udata, data_m);
      check("miss_hi_cnt", ucount, cnt_m);
      xfer(BASE - 32'h4, 1'b0, 4'b1111, 32'hA5A5A5A5, 3);
      check("miss_lo_acks", acks, 0);
      check("miss_lo_data", udata, data_m);

      // Counter wrap
      @(negedge clk);
      force dut.wr_count = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.wr_count;
      check("preload_cnt", ucount, 32'hFFFFFFFF);
      xfer(BASE, 1'b0, 4'b1111, 32'h00000001, 2);
      data_m = 32'h00000001;
      check("wrap_cnt", ucount, 32'h0);
      check("wrap_data", udata, data_m);

      // Reset in the ACK cycle of a write
      @(negedge clk);
      abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h5; sel = 1'b1;
      @(posedge clk); #1;
      check("ra_ack_seen", {31'h0, sl_ack}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("ra_ack", {31'h0, sl_ack}, 32'h0);
      check("ra_state", {30'h0, dut.state}, {30'h0, ST_IDLE});
      check("ra_data", udata, INIT);
      check("ra_cnt", ucount, 32'h0);
      acks = 0; valids = 0;
      @(negedge clk);
      sel = 1'b0; rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         sample(1'b0);
      end
      check("ra_valids", valids, 0);
      check("ra_acks", acks, 0);
      check("ra_data_after", udata, INIT);

      // Operation resumes after reset
      xfer(BASE, 1'b0, 4'b1111, 32'hCAFEF00D, 2);
      check("res_acks", acks, 1);
      check("res_data", udata, 32'hCAFEF00D);
      check("res_cnt", ucount, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
